// File: rtl/mac_stream_driver_if.sv
// mac_stream_driver_if: beat stream toward the MAC and its result return path
interface mac_stream_driver_if #(
    parameter int WIDTH = 8
);
    logic             mac_vld_o;
    logic [WIDTH-1:0] mac_win_o;
    logic [WIDTH-1:0] mac_din_o;
    logic             mac_vld_i;
    logic [WIDTH-1:0] mac_acc_i;
    modport master (output mac_vld_o, mac_win_o, mac_din_o, input mac_vld_i, mac_acc_i);
    modport slave (input mac_vld_o, mac_win_o, mac_din_o, output mac_vld_i, mac_acc_i);
endinterface

// File: rtl/mac_stream_driver.sv
// mac_stream_driver: streams a K-pair operand buffer into a MAC and captures its result
module mac_stream_driver #(
    parameter int WIDTH   = 8,
    parameter int K       = 9,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk_i,
    input  logic                 rstn,
    input  logic                 wr_en_i,
    input  logic [$clog2(K)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]     wr_w_i,
    input  logic [WIDTH-1:0]     wr_d_i,
    input  logic                 start_i,
    mac_stream_driver_if.master  mac,
    output logic [WIDTH-1:0]     res_o,
    output logic                 res_vld_o,
    output logic                 busy_o,
    output logic                 err_o
);
    localparam int AW = $clog2(K);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   KL    = (AW + 1)'(K);
    localparam logic [AW-1:0] LAST  = AW'(K - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT} state_t;

    state_t           state, state_n;
    logic [AW-1:0]    cnt, cnt_n, nxt;
    logic [TW-1:0]    tmr, tmr_n;
    logic [WIDTH-1:0] mem_w [K];
    logic [WIDTH-1:0] mem_d [K];
    logic [WIDTH-1:0] win_n, din_n, res_n;
    logic             vld_n, res_vld_n, err_n, wr_ok, hit0;

    assign wr_ok  = state == IDLE && wr_en_i && {1'b0, wr_addr_i} < KL;
    assign hit0   = wr_ok && wr_addr_i == '0;
    assign nxt    = cnt + 1'b1;
    assign busy_o = state != IDLE;

    // operand buffer: only writable while idle, cleared by reset
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < K; i++) begin
                mem_w[i] <= '0;
                mem_d[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_w[wr_addr_i] <= wr_w_i;
            mem_d[wr_addr_i] <= wr_d_i;
        end
    end

    // state, counters and every registered output
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            cnt           <= '0;
            tmr           <= '0;
            mac.mac_vld_o <= 1'b0;
            mac.mac_win_o <= '0;
            mac.mac_din_o <= '0;
            res_o         <= '0;
            res_vld_o     <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            tmr           <= tmr_n;
            mac.mac_vld_o <= vld_n;
            mac.mac_win_o <= win_n;
            mac.mac_din_o <= din_n;
            res_o         <= res_n;
            res_vld_o     <= res_vld_n;
            err_o         <= err_n;
        end
    end

    // next state and next beat; beat 0 bypasses a same-edge write to entry 0
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        tmr_n     = tmr;
        vld_n     = 1'b0;
        win_n     = '0;
        din_n     = '0;
        res_n     = res_o;
        res_vld_n = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: if (start_i) begin
                state_n = STREAM;
                cnt_n   = '0;
                vld_n   = 1'b1;
                win_n   = hit0 ? wr_w_i : mem_w[0];
                din_n   = hit0 ? wr_d_i : mem_d[0];
            end
            STREAM: if (cnt == LAST) begin
                state_n = WAIT;
                tmr_n   = '0;
            end else begin
                cnt_n = nxt;
                vld_n = 1'b1;
                win_n = mem_w[nxt];
                din_n = mem_d[nxt];
            end
            WAIT: if (mac.mac_vld_i) begin
                state_n   = IDLE;
                res_n     = mac.mac_acc_i;
                res_vld_n = 1'b1;
            end else if (tmr == TLAST) begin
                state_n = IDLE;
                err_n   = 1'b1;
            end else begin
                tmr_n = tmr + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mac_stream_driver.sv
// tb_mac_stream_driver: directed scoreboard bench for mac_stream_driver
module tb_mac_stream_driver;
    localparam int W  = 8;
    localparam int K  = 9;
    localparam int TO = 32;

    typedef struct packed {logic [W-1:0] w; logic [W-1:0] d;} beat_t;
    typedef struct packed {logic err; logic [W-1:0] val;} evt_t;

    logic         clk_i = 1'b0;
    logic         rstn = 1'b0;
    logic         wr_en_i = 1'b0;
    logic [3:0]   wr_addr_i = '0;
    logic [W-1:0] wr_w_i = '0;
    logic [W-1:0] wr_d_i = '0;
    logic         start_i = 1'b0;
    logic [W-1:0] res_o;
    logic         res_vld_o, busy_o, err_o;

    beat_t        exp_beats[$];
    evt_t         exp_evts[$];
    logic [W-1:0] mw[K];
    logic [W-1:0] md[K];
    logic [W-1:0] res_now;
    int           ncmp = 0;
    int           nerr = 0;

    mac_stream_driver_if #(.WIDTH(W)) mac ();

    mac_stream_driver #(.WIDTH(W), .K(K), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rstn(rstn), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_w_i(wr_w_i), .wr_d_i(wr_d_i), .start_i(start_i), .mac(mac),
        .res_o(res_o), .res_vld_o(res_vld_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // monitor: pops expected beats and result/error events, tracks the held result
    always @(negedge clk_i) begin
        beat_t b;
        evt_t  e;
        if (!rstn) res_now = '0;
        else begin
            if (mac.mac_vld_o) begin
                if (exp_beats.size() == 0) check("extra_beat", 1, 0);
                else begin
                    b = exp_beats.pop_front();
                    check("beat_w", mac.mac_win_o, b.w);
                    check("beat_d", mac.mac_din_o, b.d);
                end
            end else begin
                check("idle_w", mac.mac_win_o, 0);
                check("idle_d", mac.mac_din_o, 0);
            end
            if (res_vld_o || err_o) begin
                if (exp_evts.size() == 0) check("extra_evt", {res_vld_o, err_o}, 0);
                else begin
                    e = exp_evts.pop_front();
                    check("evt_err", err_o, e.err);
                    check("evt_vld", res_vld_o, !e.err);
                    res_now = e.val;
                end
            end
            check("res_hold", res_o, res_now);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [W-1:0] w, input logic [W-1:0] d, input bit upd);
        wr_en_i = 1'b1; wr_addr_i = a; wr_w_i = w; wr_d_i = d;
        if (upd && a < K) begin mw[a] = w; md[a] = d; end
        tick();
        wr_en_i = 1'b0;
    endtask

    task automatic start_burst();
        for (int i = 0; i < K; i++) exp_beats.push_back({mw[i], md[i]});
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("busy_start", busy_o, 1);
        check("vld_start", mac.mac_vld_o, 1);
    endtask

    task automatic finish_stream(input int n);
        repeat (n) tick();
        check("beats_left", exp_beats.size(), 0);
        check("vld_after", mac.mac_vld_o, 0);
        check("busy_wait", busy_o, 1);
    endtask

    task automatic respond(input int n, input logic [W-1:0] acc);
        repeat (n - 1) tick();
        mac.mac_vld_i = 1'b1; mac.mac_acc_i = acc;
        exp_evts.push_back({1'b0, acc});
        tick();
        mac.mac_vld_i = 1'b0; mac.mac_acc_i = '0;
        check("res_vld", res_vld_o, 1);
        check("res_val", res_o, acc);
        check("busy_done", busy_o, 0);
        check("no_err", err_o, 0);
        tick();
        check("res_vld_pulse", res_vld_o, 0);
    endtask

    initial begin
        mac.mac_vld_i = 1'b0;
        mac.mac_acc_i = '0;
        for (int i = 0; i < K; i++) begin mw[i] = '0; md[i] = '0; end
        repeat (3) tick();
        check("rst_busy", busy_o, 0);
        check("rst_vld", mac.mac_vld_o, 0);
        check("rst_win", mac.mac_win_o, 0);
        check("rst_res", res_o, 0);
        check("rst_rvld", res_vld_o, 0);
        check("rst_err", err_o, 0);
        rstn = 1'b1;
        tick();
        // uniform 0x40 operands, result after 5 wait cycles
        for (int i = 0; i < K; i++) wr(4'(i), 8'h40, 8'h40, 1);
        wr(4'd12, 8'hFF, 8'hFF, 0);
        start_burst();
        finish_stream(K);
        respond(5, 8'h60);
        // ramp weights; a write during streaming is dropped
        for (int i = 0; i < K; i++) wr(4'(i), 8'(i + 1), 8'h40, 1);
        start_burst();
        wr(4'd4, 8'hAA, 8'hAA, 0);
        finish_stream(K - 1);
        respond(3, 8'h55);
        start_burst();
        finish_stream(K);
        respond(1, 8'h11);
        // same-edge write to entry 0 and start
        wr_en_i = 1'b1; wr_addr_i = '0; wr_w_i = 8'h77; wr_d_i = 8'h33;
        mw[0] = 8'h77; md[0] = 8'h33;
        start_i = 1'b1;
        for (int i = 0; i < K; i++) exp_beats.push_back({mw[i], md[i]});
        tick();
        wr_en_i = 1'b0; start_i = 1'b0;
        finish_stream(K);
        respond(2, 8'h22);
        // timeout, then a normal burst
        start_burst();
        finish_stream(K);
        repeat (TO - 1) tick();
        check("err_early", err_o, 0);
        check("busy_to", busy_o, 1);
        exp_evts.push_back({1'b1, res_now});
        tick();
        check("err_pulse", err_o, 1);
        check("busy_after_to", busy_o, 0);
        check("res_kept", res_o, 8'h22);
        tick();
        check("err_once", err_o, 0);
        start_burst();
        finish_stream(K);
        respond(4, 8'h3C);
        // result on the final wait cycle wins over expiry
        start_burst();
        finish_stream(K);
        respond(TO, 8'h7E);
        // stray mac_vld_i in STREAM and start_i in WAIT
        start_burst();
        tick();
        mac.mac_vld_i = 1'b1; mac.mac_acc_i = 8'hEE;
        tick();
        mac.mac_vld_i = 1'b0; mac.mac_acc_i = '0;
        finish_stream(K - 2);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("res_unchanged", res_o, 8'h7E);
        respond(3, 8'h5A);
        repeat (3) tick();
        check("no_rerun_vld", mac.mac_vld_o, 0);
        check("no_rerun_busy", busy_o, 0);
        // reset on beat 5
        start_burst();
        repeat (5) tick();
        rstn = 1'b0;
        #1;
        exp_beats.delete();
        for (int i = 0; i < K; i++) begin mw[i] = '0; md[i] = '0; end
        check("abort_vld", mac.mac_vld_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_win", mac.mac_win_o, 0);
        check("abort_res", res_o, 0);
        repeat (2) tick();
        rstn = 1'b1;
        repeat (TO + 5) tick();
        start_burst();
        finish_stream(K);
        respond(2, 8'h01);
        repeat (4) tick();
        check("evts_left", exp_evts.size(), 0);
        check("beats_end", exp_beats.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
